// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, computed as a + ~b + 1 through
// one full-adder cell with a registered carry, behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_a_q, sreg_a_d;
    logic [WIDTH-1:0]   sreg_b_q, sreg_b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;

    logic               sum_bit;
    logic               carry_next;
    logic               last_bit;

    // Full-adder cell on the current LSBs of the operand shift registers.
    assign sum_bit    = sreg_a_q[0] ^ sreg_b_q[0] ^ carry_q;
    assign carry_next = (sreg_a_q[0] & sreg_b_q[0]) | (sreg_a_q[0] & carry_q) |
                        (sreg_b_q[0] & carry_q);
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d  = state_q;
        sreg_a_d = sreg_a_q;
        sreg_b_d = sreg_b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sreg_a_d = a;
                    sreg_b_d = ~b;
                    carry_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                res_d    = {sum_bit, res_q[WIDTH-1:1]};
                sreg_a_d = {1'b0, sreg_a_q[WIDTH-1:1]};
                sreg_b_d = {1'b0, sreg_b_q[WIDTH-1:1]};
                carry_d  = carry_next;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // On the MSB, sreg_a[0] is a's sign and sreg_b[0] is the inverted sign of b.
                    diff_d   = {sum_bit, res_q[WIDTH-1:1]};
                    borrow_d = ~carry_next;
                    ovf_d    = (sreg_a_q[0] == sreg_b_q[0]) && (sum_bit != sreg_a_q[0]);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            sreg_a_q <= sreg_a_d;
            sreg_b_q <= sreg_b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver queues expected results,
// the monitor pops one on every done pulse and checks held outputs otherwise.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } result_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    result_t exp_q[$];
    result_t hold;
    int      n_cmp = 0;
    int      n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        result_t r;
        r.diff   = x - y;
        r.borrow = (x < y);
        r.ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (r.diff[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    function automatic result_t mk(input logic [WIDTH-1:0] d, input logic br, input logic ov);
        result_t r;
        r.diff   = d;
        r.borrow = br;
        r.ovf    = ov;
        return r;
    endfunction

    // One accepted start followed by WIDTH cycles; returns at the negedge where done is high.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input result_t e);
        start = 1'b1;
        a = x;
        b = y;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~x;
        b = ~y;
        repeat (WIDTH) @(negedge clk);
    endtask

    // Monitor: compare on done, otherwise the outputs must hold the last result.
    initial begin
        result_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: diff=%0h with empty scoreboard", diff);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {diff, borrow_out, overflow}, {e.diff, e.borrow, e.ovf});
                        hold = e;
                    end
                end else begin
                    check("held", {diff, borrow_out, overflow}, {hold.diff, hold.borrow, hold.ovf});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        hold = mk('0, 1'b0, 1'b0);
        #12;
        check("reset_outputs", {busy, done, diff, borrow_out, overflow}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // First operation with explicit handshake timing.
        start = 1'b1; a = 4'd7; b = 4'd3;
        exp_q.push_back(mk(4'd4, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0; a = 4'hF; b = 4'hF;
        check("busy_c1", {busy, done}, 2'b10);
        for (int i = 2; i <= WIDTH; i++) begin
            @(negedge clk);
            check("busy_cn", {busy, done}, 2'b10);
        end
        @(negedge clk);
        check("done_pulse", {busy, done}, 2'b01);
        @(negedge clk);
        check("done_clear", {busy, done}, 2'b00);

        // Directed vectors, issued back-to-back from DONE.
        issue(4'd3, 4'd7, mk(4'hC, 1'b1, 1'b0));
        issue(4'd0, 4'd0, mk(4'h0, 1'b0, 1'b0));
        issue(4'h8, 4'd1, mk(4'h7, 1'b0, 1'b1));
        issue(4'd7, 4'h8, mk(4'hF, 1'b1, 1'b1));
        @(negedge clk);

        // Start held high; junk operands while busy must not be captured.
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 4'(3 * i + 2);
            b = 4'(5 * i + 1);
            exp_q.push_back(model(a, b));
            @(negedge clk);
            for (int j = 0; j < WIDTH; j++) begin
                a = 4'(j + 9);
                b = 4'(14 - j);
                @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset two cycles into an operation.
        start = 1'b1; a = 4'd5; b = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        hold = mk('0, 1'b0, 1'b0);
        #1;
        check("async_reset", {busy, done, diff, borrow_out, overflow}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (WIDTH + 2) @(negedge clk);
        issue(4'd9, 4'd4, mk(4'h5, 1'b0, 1'b1));
        @(negedge clk);

        // Exhaustive sweep against the reference model.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                issue(4'(x), 4'(y), model(4'(x), 4'(y)));
        @(negedge clk);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
